// File: rtl/imem_prog_if.sv
// IMEM programming controller bus: programming stream,
// core fetch path and IMEM port grouped in one interface.
package imem_prog_pkg;
  typedef logic [31:0] u32_t;
  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } prog_st_t;
endpackage

interface imem_prog_if #(
  parameter int AW    = 8,
  parameter int LEN_W = 9
);
  import imem_prog_pkg::*;

  logic             prog_start;
  logic [LEN_W-1:0] prog_len;
  logic             prog_abort;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             prog_busy;
  logic             prog_done;
  logic             prog_err;
  logic             core_stall;
  logic             fetch_req;
  u32_t             fetch_addr;
  logic             fetch_gnt;
  logic             fetch_misalign;
  u32_t             fetch_data;
  logic [AW-1:0]    mem_addr;
  logic             mem_we;
  u32_t             mem_wdata;
  u32_t             mem_rdata;

  modport master (
    output prog_start,
    output prog_len,
    output prog_abort,
    output byte_valid,
    output byte_data,
    output fetch_req,
    output fetch_addr,
    output mem_rdata,
    input  byte_ready,
    input  prog_busy,
    input  prog_done,
    input  prog_err,
    input  core_stall,
    input  fetch_gnt,
    input  fetch_misalign,
    input  fetch_data,
    input  mem_addr,
    input  mem_we,
    input  mem_wdata
  );

  modport slave (
    input  prog_start,
    input  prog_len,
    input  prog_abort,
    input  byte_valid,
    input  byte_data,
    input  fetch_req,
    input  fetch_addr,
    input  mem_rdata,
    output byte_ready,
    output prog_busy,
    output prog_done,
    output prog_err,
    output core_stall,
    output fetch_gnt,
    output fetch_misalign,
    output fetch_data,
    output mem_addr,
    output mem_we,
    output mem_wdata
  );
endinterface

// File: rtl/imem_prog.sv
// IMEM programming controller and port arbiter: passes fetches
// through when idle, writes a LE byte stream into IMEM otherwise.
module imem_prog
  import imem_prog_pkg::*;
#(
  parameter int WORDS = 256,
  parameter int LEN_W = 9
) (
  input logic        clk,
  input logic        rst_n,
  imem_prog_if.slave bus
);
  localparam int AW = $clog2(WORDS);
  localparam logic [LEN_W-1:0] LEN_MAX =
    LEN_W'(WORDS);

  prog_st_t         state_q;
  prog_st_t         state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_sat;
  logic [AW:0]      wcnt_q;
  logic [1:0]       bcnt_q;
  logic [3:0][7:0]  sh_q;
  logic             err_q;
  logic             idle;
  logic             abort;
  logic             take;
  logic             last_word;
  logic             unused_addr;

  assign idle  = (state_q == S_IDLE);
  assign abort = ~idle & bus.prog_abort;

  assign len_sat =
    (bus.prog_len > LEN_MAX) ? LEN_MAX
                             : bus.prog_len;

  assign take = (state_q == S_COLLECT)
              & bus.byte_valid
              & ~bus.prog_abort;

  // wcnt is one bit wider than the index so
  // a full-depth session ends without wrapping
  assign last_word =
    (32'(wcnt_q) + 32'd1) == 32'(len_q);

  assign unused_addr =
    ^{bus.fetch_addr[31:AW+2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    bus.byte_ready     = 1'b0;
    bus.prog_busy      = 1'b0;
    bus.prog_done      = 1'b0;
    bus.core_stall     = 1'b0;
    bus.mem_we         = 1'b0;
    bus.mem_addr       = '0;
    bus.fetch_gnt      = 1'b0;
    bus.fetch_misalign = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.prog_start) begin
          if (len_sat == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (take && bcnt_q == 2'd3) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (last_word) begin
          state_d = S_DONE;
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d = S_IDLE;
    end

    unique case (1'b1)
      idle: begin
        bus.mem_addr =
          bus.fetch_addr[AW+1:2];
        bus.fetch_gnt =
          rst_n & bus.fetch_req;
        bus.fetch_misalign =
          bus.fetch_req
          & |bus.fetch_addr[1:0];
      end
      default: begin
        bus.mem_addr   = wcnt_q[AW-1:0];
        bus.prog_busy  = 1'b1;
        bus.core_stall = 1'b1;
      end
    endcase

    bus.byte_ready = (state_q == S_COLLECT);
    bus.prog_done  = (state_q == S_DONE);
    // an abort on the write beat drops the word
    bus.mem_we = (state_q == S_WRITE)
               & ~bus.prog_abort;
  end

  assign bus.fetch_data =
    bus.fetch_gnt ? bus.mem_rdata : '0;
  assign bus.mem_wdata = sh_q;
  assign bus.prog_err  = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      wcnt_q <= '0;
      bcnt_q <= '0;
      sh_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= abort;
      if (abort) begin
        bcnt_q <= '0;
        sh_q   <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.prog_start) begin
              len_q  <= len_sat;
              wcnt_q <= '0;
              bcnt_q <= '0;
              sh_q   <= '0;
            end
          end
          S_COLLECT: begin
            if (take) begin
              sh_q[bcnt_q] <= bus.byte_data;
              bcnt_q       <= bcnt_q + 2'd1;
            end
          end
          S_WRITE: begin
            if (!last_word) begin
              wcnt_q <= wcnt_q + 1'b1;
            end
            bcnt_q <= '0;
          end
          default: begin
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imem_prog.sv
// Randomised bench for imem_prog: byte streams are turned into
// expected IMEM words and compared with the observed writes.
module tb_imem_prog;
  import imem_prog_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_init = 1'b1;

  always #5 clk = ~clk;

  imem_prog_if #(.AW(8), .LEN_W(9)) bif ();

  imem_prog #(
    .WORDS(256),
    .LEN_W(9)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif.slave)
  );

  u32_t imem [256];
  u32_t img  [256];
  int   wl_a [$];
  u32_t wl_d [$];
  int   checks = 0;
  int   fails  = 0;

  assign bif.mem_rdata = imem[bif.mem_addr];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++)
        imem[i] <= img[i];
    end else if (bif.mem_we === 1'b1) begin
      imem[bif.mem_addr] <= bif.mem_wdata;
      wl_a.push_back(int'(bif.mem_addr));
      wl_d.push_back(bif.mem_wdata);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%08h exp=%08h",
               tag, got, exp);
    end
  endtask

  task automatic fetch(input u32_t addr);
    int w;
    w = int'(addr[9:2]);
    @(negedge clk);
    bif.fetch_req  = 1'b1;
    bif.fetch_addr = addr;
    #1;
    check("fetch_gnt", 32'(bif.fetch_gnt), 1);
    check("fetch_addr", 32'(bif.mem_addr), w);
    check("fetch_data", bif.fetch_data, img[w]);
    check("fetch_mis", 32'(bif.fetch_misalign),
          32'(addr[1:0] != 2'd0));
    bif.fetch_req = 1'b0;
  endtask

  task automatic session(input int len,
                         input int mode,
                         input int abort_at,
                         input bit restart,
                         input string tag);
    logic [7:0] q [$];
    int n, nw, idx, cyc, dones;
    bit stall_ok, fetch_ok, aborted, bv;
    u32_t w;
    n = (len > 256) ? 256 : len;
    idx = 0; dones = 0;
    stall_ok = 1; fetch_ok = 1; aborted = 0;
    for (int i = 0; i < 4 * n; i++)
      q.push_back(8'($urandom));
    wl_a.delete();
    wl_d.delete();
    @(negedge clk);
    bif.prog_start = 1'b1;
    bif.prog_len   = 9'(len);
    bif.fetch_req  = 1'b0;
    @(negedge clk);
    bif.prog_start = 1'b0;
    cyc = 1;
    while (bif.prog_busy === 1'b1 && cyc < 20000) begin
      cyc++;
      bif.prog_abort = 1'b0;
      bif.prog_start = restart && (cyc == 4);
      case (mode)
        0:       bv = 1'b1;
        1:       bv = cyc[0];
        default: bv = 1'($urandom_range(0, 1));
      endcase
      bif.byte_valid = bv;
      bif.byte_data  = (idx < q.size()) ?
                       q[idx] : 8'($urandom);
      bif.fetch_req  = 1'($urandom_range(0, 1));
      bif.fetch_addr = $urandom;
      if (abort_at >= 0 && idx == abort_at &&
          bif.byte_ready === 1'b1 && !aborted) begin
        bif.prog_abort = 1'b1;
        aborted = 1;
      end
      #1;
      if (bif.core_stall !== 1'b1) stall_ok = 0;
      if (bif.fetch_gnt !== 1'b0 ||
          bif.fetch_data !== 32'd0 ||
          bif.fetch_misalign !== 1'b0)
        fetch_ok = 0;
      if (bif.prog_done === 1'b1) dones++;
      if (bif.byte_ready === 1'b1 && bv &&
          !bif.prog_abort)
        idx++;
      @(negedge clk);
    end
    bif.prog_start = 1'b0;
    bif.prog_abort = 1'b0;
    bif.byte_valid = 1'b0;
    bif.fetch_req  = 1'b0;
    #1;
    check({tag, " busy_end"}, 32'(bif.prog_busy), 0);
    check({tag, " err"}, 32'(bif.prog_err),
          32'(aborted));
    check({tag, " dones"}, dones, aborted ? 0 : 1);
    check({tag, " stall"}, 32'(stall_ok), 1);
    check({tag, " nofetch"}, 32'(fetch_ok), 1);
    if (mode == 0 && !aborted)
      check({tag, " cycles"}, cyc, 2 + 5 * n);
    nw = aborted ? abort_at / 4 : n;
    check({tag, " nwrites"}, wl_a.size(), nw);
    for (int i = 0; i < nw && i < wl_a.size(); i++) begin
      w = {q[4*i+3], q[4*i+2], q[4*i+1], q[4*i]};
      check({tag, " waddr"}, wl_a[i], i);
      check({tag, " wdata"}, wl_d[i], w);
      img[i] = w;
    end
    @(negedge clk);
    #1;
    check({tag, " err_once"}, 32'(bif.prog_err), 0);
  endtask

  task automatic reset_mid;
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    @(negedge clk);
    bif.prog_start = 1'b1;
    bif.prog_len   = 9'd4;
    @(negedge clk);
    bif.prog_start = 1'b0;
    bif.byte_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bif.byte_data = (k < 4) ? b[k] : 8'h00;
      @(negedge clk);
    end
    bif.byte_valid = 1'b0;
    rst_n = 1'b0;
    bif.fetch_req  = 1'b1;
    bif.fetch_addr = 32'h0;
    #1;
    check("rst_mid busy", 32'(bif.prog_busy), 0);
    check("rst_mid stall", 32'(bif.core_stall), 0);
    check("rst_mid err", 32'(bif.prog_err), 0);
    check("rst_mid done", 32'(bif.prog_done), 0);
    check("rst_mid gnt", 32'(bif.fetch_gnt), 0);
    check("rst_mid data", bif.fetch_data, 0);
    bif.fetch_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    img[0] = {b[3], b[2], b[1], b[0]};
    @(negedge clk);
    #1;
    check("rst_mid err2", 32'(bif.prog_err), 0);
    check("rst_mid busy2", 32'(bif.prog_busy), 0);
  endtask

  initial begin
    int len, ab;
    bif.prog_start = 1'b0;
    bif.prog_len   = '0;
    bif.prog_abort = 1'b0;
    bif.byte_valid = 1'b0;
    bif.byte_data  = '0;
    bif.fetch_req  = 1'b1;
    bif.fetch_addr = 32'h0000_0008;
    for (int i = 0; i < 256; i++) img[i] = $urandom;
    img[2] = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    #1;
    check("rst byte_ready", 32'(bif.byte_ready), 0);
    check("rst busy", 32'(bif.prog_busy), 0);
    check("rst done", 32'(bif.prog_done), 0);
    check("rst err", 32'(bif.prog_err), 0);
    check("rst stall", 32'(bif.core_stall), 0);
    check("rst we", 32'(bif.mem_we), 0);
    check("rst gnt", 32'(bif.fetch_gnt), 0);
    check("rst data", bif.fetch_data, 0);
    mem_init = 1'b0;
    rst_n = 1'b1;
    fetch(32'h0000_0008);
    fetch(32'h0000_0006);
    @(negedge clk);
    #1;
    check("idle gnt0", 32'(bif.fetch_gnt), 0);
    check("idle data0", bif.fetch_data, 0);

    session(2, 0, -1, 0, "len2");
    session(1, 1, -1, 0, "toggle");
    session(3, 2, 6, 0, "abort");
    fetch(32'h0000_0000);
    fetch(32'h0000_0004);
    session(0, 0, -1, 0, "len0");
    session(2, 0, -1, 1, "restart");
    fetch(32'h0000_0006);
    repeat (6) begin
      len = $urandom_range(1, 8);
      ab  = ($urandom_range(0, 2) == 0) ?
            $urandom_range(0, 4 * len - 1) : -1;
      session(len, $urandom_range(0, 2), ab,
              1'($urandom_range(0, 1)), "rand");
    end
    session(300, 2, -1, 0, "sat");
    reset_mid();
    for (int w = 0; w < 256; w++)
      fetch({20'($urandom), 8'(w), 2'($urandom), 2'b0}
            | 32'($urandom_range(0, 3)));
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end
endmodule

// File: doc/imem_prog.md
# imem_prog

Instruction-memory programming controller and port arbiter for the 256-word (1 KiB) IMEM. It sits between the core fetch path and the IMEM array and owns the single address/write port. When idle it passes core fetches straight through. During a programming session it stalls the core and assembles a byte stream, little-endian, into 32-bit words written at auto-incrementing addresses.

## Interface
Parameters:
- WORDS, 256, IMEM depth in words; address index width AW = $clog2(WORDS) = 8
- LEN_W, 9, width of prog_len (must hold WORDS)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- prog_start  in  1  single-cycle request to begin a session at word 0; ignored unless IDLE
- prog_len  in  LEN_W  words to program; sampled on accepted prog_start; values > WORDS saturate to WORDS
- prog_abort  in  1  terminate the session; wins over all other inputs
- byte_valid  in  1  programming byte present
- byte_data  in  8  programming byte
- byte_ready  out  1  controller accepts byte_data this cycle
- prog_busy  out  1  session in progress (COLLECT/WRITE/DONE)
- prog_done  out  1  one-cycle pulse, session completed normally
- prog_err  out  1  one-cycle pulse, session aborted
- core_stall  out  1  core must hold its fetch PC; equals prog_busy
- fetch_req  in  1  core fetch request
- fetch_addr  in  u32_t  core byte address
- fetch_gnt  out  1  fetch served this cycle
- fetch_misalign  out  1  fetch_req with fetch_addr[1:0] != 0
- fetch_data  out  u32_t  instruction word to core
- mem_addr  out  AW  IMEM word index
- mem_we  out  1  IMEM write enable, sampled by IMEM on clk
- mem_wdata  out  u32_t  IMEM write data
- mem_rdata  in  u32_t  IMEM combinational read data

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: mem_addr = fetch_addr[9:2]; fetch_gnt = fetch_req; fetch_data = fetch_gnt ? mem_rdata : 0; fetch_misalign = fetch_req & |fetch_addr[1:0]; the misaligned fetch is still granted with the address truncated. mem_we = 0, byte_ready = 0.
- IDLE + prog_start: if the saturated prog_len = 0, go to DONE. Otherwise latch the length, clear word counter wcnt and byte counter bcnt, and go to COLLECT.
- COLLECT: byte_ready = 1. On byte_valid & byte_ready, byte_data goes to shift-register lane bcnt (lane 0 = bits 7:0) and bcnt increments. The 4th byte (bcnt = 3) goes to WRITE.
- WRITE: mem_we = 1, mem_addr = wcnt, mem_wdata = assembled word, byte_ready = 0. Next state: wcnt+1 == len -> DONE, else wcnt++, bcnt = 0 -> COLLECT.
- DONE: prog_done = 1 for exactly this cycle (including the len = 0 case); next state IDLE.
- Outside IDLE: fetch_gnt = 0, fetch_data = 0, fetch_misalign = 0, mem_addr = wcnt (in WRITE).
- prog_abort in any non-IDLE state: go to IDLE next cycle, discard the partial word, and pulse prog_err in that next cycle. A write in progress that cycle is suppressed (mem_we = 0). prog_abort in IDLE has no effect.
- prog_start outside IDLE is ignored; it does not restart the session.
- wcnt is AW+1 bits so len = 256 terminates without wrap; words already written are never rewritten within a session.

## Timing
- Reset (rst_n low, async): state IDLE, wcnt = bcnt = 0, the shift register and length cleared. All registered outputs are 0: byte_ready, prog_busy, prog_done, prog_err, core_stall, mem_we. fetch_gnt and fetch_data are also forced to 0 while rst_n is low.
- Reset mid-session abandons it with no prog_err or prog_done pulse; IMEM contents written so far remain.
- Fetch path is combinational, zero-cycle latency in IDLE.
- Minimum session cycle count: 1 (start) + 5 per word (4 COLLECT beats + WRITE) + 1 DONE. A stalled byte_valid extends COLLECT with no limit.
- core_stall rises the cycle after prog_start is accepted and falls the cycle after DONE.

## Test plan
- Reset then IDLE fetch with fetch_addr = 0x0000_0008, mem_rdata = 0xDEAD_BEEF -> mem_addr = 2, fetch_gnt = 1, fetch_data = 0xDEAD_BEEF; with rst_n low, fetch_data = 0.
- prog_len = 2, bytes 11 22 33 44 55 66 77 88 back-to-back -> mem_we pulses writing addr 0 = 0x4433_2211 and addr 1 = 0x8877_6655. Session is 12 cycles start-to-IDLE; prog_done pulses once; core_stall stays high throughout.
- byte_valid toggled 1/0 every cycle with prog_len = 1 -> a single write of the correct word, with no byte lost or duplicated.
- Abort after 2 bytes of word 1 with prog_len = 3 -> no write to addr 1, prog_err pulses once, state IDLE, fetches granted again.
- prog_len = 0 -> DONE next cycle, prog_done pulses, no mem_we; prog_len = 300 -> exactly 256 writes, addr 0..255.
- prog_start pulsed again mid-session, plus a misaligned fetch 0x0000_0006 in IDLE -> session unaffected; the fetch gives fetch_misalign = 1, mem_addr = 1.
